// File: rtl/gpu_pkg.sv
// Shared constants and types for the tile graphics path (raster counter and pixel pipe).
package gpu_pkg;
    localparam int unsigned HW          = 1088;
    localparam int unsigned VW          = 517;
    localparam int unsigned TILES_X     = 72;
    localparam int unsigned TILES_Y     = 54;
    localparam int unsigned H_SYNC_LEN  = 112;
    localparam int unsigned V_SYNC_LEN  = 3;
    localparam int unsigned PIPE_LAT    = 3;
    localparam int unsigned PAL_ENTRIES = 16;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] glyph;
    } tile_word_t;
endpackage

// File: rtl/gpu_palette.sv
// Double-buffered 16-entry RGB444 palette: writes land in the shadow bank,
// and the shadow bank is copied to the active bank at frame start.
module gpu_palette
    import gpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  rgb444_t    wdata,
    input  logic       commit,
    input  logic [3:0] rd_idx,
    output rgb444_t    rd_data
);
    rgb444_t shadow_q [PAL_ENTRIES];
    rgb444_t shadow_d [PAL_ENTRIES];
    rgb444_t active_q [PAL_ENTRIES];
    rgb444_t active_d [PAL_ENTRIES];

    // Commit reads shadow_q, so a write in the commit cycle waits for the next frame.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (we) begin
            shadow_d[waddr] = wdata;
        end
        if (commit) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign rd_data = active_q[rd_idx];
endmodule

// File: rtl/tile_pixel_pipe.sv
// Tile-based pixel generator: tile RAM -> pattern ROM -> palette, with syncs and
// data-enable carried alongside so every output has the same 3-clock latency.
module tile_pixel_pipe #(
    parameter int unsigned H_SYNC_LEN = gpu_pkg::H_SYNC_LEN,
    parameter int unsigned V_SYNC_LEN = gpu_pkg::V_SYNC_LEN,
    parameter int unsigned TILES_X    = gpu_pkg::TILES_X
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cnt_h,
    input  logic [9:0]  cnt_v,
    input  logic [6:0]  blk_x,
    input  logic [5:0]  blk_y,
    input  logic [2:0]  off_x,
    input  logic [2:0]  off_y,
    input  logic        in_mem,
    output logic        tile_rd,
    output logic [11:0] tile_addr,
    input  logic [15:0] tile_data,
    output logic [10:0] pat_addr,
    input  logic [7:0]  pat_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    output logic [11:0] rgb,
    output logic        de,
    output logic        hsync_n,
    output logic        vsync_n
);
    import gpu_pkg::*;

    tile_word_t  tile_w;
    logic [11:0] by_ext;
    logic [11:0] bx_ext;
    logic        hs_raw;
    logic        vs_raw;
    logic        frame_start;
    logic        pix_bit;
    logic [3:0]  pal_idx;
    rgb444_t     pal_rgb;

    logic [2:0] off_x_s1_q, off_x_s1_d;
    logic [2:0] off_y_s1_q, off_y_s1_d;
    logic       in_mem_s1_q, in_mem_s1_d;
    logic       hs_s1_q, hs_s1_d;
    logic       vs_s1_q, vs_s1_d;

    logic [2:0] off_x_s2_q, off_x_s2_d;
    logic [3:0] fg_s2_q, fg_s2_d;
    logic [3:0] bg_s2_q, bg_s2_d;
    logic       in_mem_s2_q, in_mem_s2_d;
    logic       hs_s2_q, hs_s2_d;
    logic       vs_s2_q, vs_s2_d;

    rgb444_t    rgb_q, rgb_d;
    logic       de_q, de_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;

    assign by_ext = {6'd0, blk_y};
    assign bx_ext = {5'd0, blk_x};

    // 72 = 64 + 8, so the default stride needs only shifts and adds.
    generate
        if (TILES_X == 72) begin : g_addr_shift
            assign tile_addr = (by_ext << 6) + (by_ext << 3) + bx_ext;
        end else begin : g_addr_mul
            assign tile_addr = 12'(by_ext * 12'(TILES_X)) + bx_ext;
        end
    endgenerate

    assign tile_rd     = in_mem & ~rst;
    assign hs_raw      = (cnt_h < 11'(H_SYNC_LEN));
    assign vs_raw      = (cnt_v < 10'(V_SYNC_LEN));
    assign frame_start = (cnt_h == 11'd0) && (cnt_v == 10'd0);

    assign tile_w   = tile_word_t'(tile_data);
    assign pat_addr = {tile_w.glyph, off_y_s1_q};
    assign pix_bit  = pat_data[3'd7 - off_x_s2_q];
    assign pal_idx  = pix_bit ? fg_s2_q : bg_s2_q;

    gpu_palette u_palette (
        .clk     (clk),
        .rst     (rst),
        .we      (pal_we),
        .waddr   (pal_addr),
        .wdata   (pal_data),
        .commit  (frame_start),
        .rd_idx  (pal_idx),
        .rd_data (pal_rgb)
    );

    always_comb begin
        off_x_s1_d  = off_x;
        off_y_s1_d  = off_y;
        in_mem_s1_d = in_mem;
        hs_s1_d     = hs_raw;
        vs_s1_d     = vs_raw;

        off_x_s2_d  = off_x_s1_q;
        fg_s2_d     = tile_w.fg;
        bg_s2_d     = tile_w.bg;
        in_mem_s2_d = in_mem_s1_q;
        hs_s2_d     = hs_s1_q;
        vs_s2_d     = vs_s1_q;

        rgb_d       = in_mem_s2_q ? pal_rgb : 12'h000;
        de_d        = in_mem_s2_q;
        hsync_n_d   = ~hs_s2_q;
        vsync_n_d   = ~vs_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_x_s1_q  <= '0;
            off_y_s1_q  <= '0;
            in_mem_s1_q <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            off_x_s2_q  <= '0;
            fg_s2_q     <= '0;
            bg_s2_q     <= '0;
            in_mem_s2_q <= 1'b0;
            hs_s2_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
        end else begin
            off_x_s1_q  <= off_x_s1_d;
            off_y_s1_q  <= off_y_s1_d;
            in_mem_s1_q <= in_mem_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            off_x_s2_q  <= off_x_s2_d;
            fg_s2_q     <= fg_s2_d;
            bg_s2_q     <= bg_s2_d;
            in_mem_s2_q <= in_mem_s2_d;
            hs_s2_q     <= hs_s2_d;
            vs_s2_q     <= vs_s2_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
        end
    end

    assign rgb     = rgb_q;
    assign de      = de_q;
    assign hsync_n = hsync_n_q;
    assign vsync_n = vsync_n_q;
endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Scoreboard bench for tile_pixel_pipe: expected outputs are queued when stimulus is driven
// and compared three cycles later against the registered outputs.
module tb_tile_pixel_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] cnt_h = '0;
    logic [9:0]  cnt_v = '0;
    logic [6:0]  blk_x = '0;
    logic [5:0]  blk_y = '0;
    logic [2:0]  off_x = '0;
    logic [2:0]  off_y = '0;
    logic        in_mem = 1'b0;
    logic        tile_rd;
    logic [11:0] tile_addr;
    logic [15:0] tile_data = '0;
    logic [10:0] pat_addr;
    logic [7:0]  pat_data = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;
    logic [11:0] rgb;
    logic        de;
    logic        hsync_n;
    logic        vsync_n;

    typedef struct {
        int          ch;
        int          cv;
        int          bx;
        int          by;
        int          ox;
        int          oy;
        logic        im;
        logic        we;
        int          wa;
        logic [11:0] wd;
    } stim_t;

    localparam logic [14:0] RST_V = {12'h000, 1'b0, 1'b1, 1'b1};

    logic [15:0] tile_mem [4096];
    logic [7:0]  pat_mem  [2048];
    logic [11:0] m_shadow [16];
    logic [11:0] m_active [16];
    logic [14:0] sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    tile_pixel_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_h     (cnt_h),
        .cnt_v     (cnt_v),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .off_x     (off_x),
        .off_y     (off_y),
        .in_mem    (in_mem),
        .tile_rd   (tile_rd),
        .tile_addr (tile_addr),
        .tile_data (tile_data),
        .pat_addr  (pat_addr),
        .pat_data  (pat_data),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .rgb       (rgb),
        .de        (de),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tile_rd) tile_data <= tile_mem[tile_addr];
        pat_data <= pat_mem[pat_addr];
    end

    function automatic stim_t px(input int bx, input int by, input int ox, input int oy);
        stim_t s;
        s = '{ch: 400, cv: 100, bx: bx, by: by, ox: ox, oy: oy, im: 1'b1, we: 1'b0, wa: 0, wd: 12'h000};
        return s;
    endfunction

    function automatic stim_t idle(input int ch, input int cv);
        stim_t s;
        s = '{ch: ch, cv: cv, bx: 0, by: 0, ox: 0, oy: 0, im: 1'b0, we: 1'b0, wa: 0, wd: 12'h000};
        return s;
    endfunction

    function automatic stim_t pwrite(input int ch, input int cv, input int wa, input logic [11:0] wd);
        stim_t s;
        s = idle(ch, cv);
        s.we = 1'b1;
        s.wa = wa;
        s.wd = wd;
        return s;
    endfunction

    // Applies one cycle of stimulus, queues its expected output, then advances the palette model.
    task automatic drive(input stim_t s);
        logic [15:0] tw;
        logic [7:0]  p;
        logic [3:0]  idx;
        logic [11:0] col;
        cnt_h    = 11'(s.ch);
        cnt_v    = 10'(s.cv);
        blk_x    = 7'(s.bx);
        blk_y    = 6'(s.by);
        off_x    = 3'(s.ox);
        off_y    = 3'(s.oy);
        in_mem   = s.im;
        pal_we   = s.we;
        pal_addr = 4'(s.wa);
        pal_data = s.wd;
        if (rst) begin
            sb.push_back(RST_V);
        end else begin
            tw  = tile_mem[s.by * 72 + s.bx];
            p   = pat_mem[{tw[7:0], 3'(s.oy)}];
            idx = p[7 - s.ox] ? tw[11:8] : tw[15:12];
            col = s.im ? m_active[idx] : 12'h000;
            sb.push_back({col, s.im, ~(s.ch < 112), ~(s.cv < 3)});
            if (s.ch == 0 && s.cv == 0) m_active = m_shadow;
            if (s.we) m_shadow[s.wa] = s.wd;
        end
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        stim_t s;
        s = px(5, 2, 0, 0);
        in_mem = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({rgb, de, hsync_n, vsync_n, tile_rd} !== {RST_V, 1'b0}) begin
            $display("FAIL reset_hold: out=%h tile_rd=%b exp=%h tile_rd=0", {rgb, de, hsync_n, vsync_n}, tile_rd, RST_V);
        end else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL reset_out: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            if (i == 5) rst = 1'b0;
            drive(i == 5 ? idle(500, 100) : s);
            #1;
            if (rst) begin
                n_checks++;
                if (tile_rd !== 1'b0) $display("FAIL reset_tile_rd: tile_rd=%b exp=0", tile_rd);
                else n_pass++;
            end
        end
    endtask

    task automatic test_palette_load();
        logic [14:0] exp_v;
        stim_t tab[$];
        for (int i = 0; i < 16; i++) begin
            tab.push_back(pwrite(500, 100, i, (i == 3) ? 12'hF00 : (i == 10) ? 12'h0AB : 12'($urandom)));
        end
        tab.push_back(idle(1087, 516));
        tab.push_back(idle(0, 0));
        tab.push_back(px(5, 2, 0, 0));
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL palette_load: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            drive(tab[i]);
        end
    endtask

    task automatic test_pixels(input string name, input stim_t tab[$], input logic [14:0] first_exp);
        logic [14:0] exp_v;
        int          addr_exp;
        for (int i = 0; i < tab.size() + 3; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL %s: out=%h exp=%h", name, {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            if (i == 3 && first_exp !== 15'h7fff) begin
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== first_exp) begin
                    $display("FAIL %s_fixed: out=%h exp=%h", name, {rgb, de, hsync_n, vsync_n}, first_exp);
                end else n_pass++;
            end
            if (i < tab.size()) begin
                drive(tab[i]);
                #1;
                addr_exp = tab[i].by * 72 + tab[i].bx;
                n_checks++;
                if (tile_rd !== tab[i].im || tile_addr !== 12'(addr_exp)) begin
                    $display("FAIL %s_addr: tile_rd=%b tile_addr=%0d exp tile_rd=%b tile_addr=%0d",
                             name, tile_rd, tile_addr, tab[i].im, addr_exp);
                end else n_pass++;
            end else begin
                drive(idle(500, 100));
            end
        end
    endtask

    task automatic test_address_latency();
        stim_t tab[$];
        tab.push_back(px(5, 2, 0, 0));
        test_pixels("addr_latency", tab, {12'hF00, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_background();
        stim_t tab[$];
        tab.push_back(px(5, 2, 1, 0));
        for (int ox = 0; ox < 8; ox++) tab.push_back(px(5, 2, ox, 0));
        test_pixels("background", tab, {12'h0AB, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_outside();
        stim_t tab[$];
        stim_t s;
        s = px(5, 2, 0, 0);
        s.im = 1'b0;
        tab.push_back(s);
        tab.push_back(px(5, 2, 0, 0));
        tab.push_back(s);
        test_pixels("outside", tab, RST_V);
    endtask

    task automatic test_back_to_back();
        stim_t tab[$];
        stim_t s;
        for (int i = 0; i < 24; i++) begin
            s = px($urandom_range(71), $urandom_range(53), $urandom_range(7), $urandom_range(7));
            s.ch = $urandom_range(1000, 200);
            s.cv = $urandom_range(500, 10);
            tab.push_back(s);
        end
        test_pixels("back_to_back", tab, 15'h7fff);
    endtask

    task automatic test_syncs();
        logic [14:0] exp_v;
        stim_t tab[$];
        logic [1:0] want [$];
        tab.push_back(idle(111, 100)); want.push_back(2'b01);
        tab.push_back(idle(112, 100)); want.push_back(2'b11);
        tab.push_back(idle(600, 2));   want.push_back(2'b10);
        tab.push_back(idle(600, 3));   want.push_back(2'b11);
        tab.push_back(idle(1087, 516)); want.push_back(2'b11);
        tab.push_back(idle(0, 516));   want.push_back(2'b01);
        tab.push_back(idle(1087, 100)); want.push_back(2'b11);
        tab.push_back(idle(0, 100));   want.push_back(2'b01);
        for (int i = 0; i < tab.size() + 3; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL syncs: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            if (i >= 3) begin
                n_checks++;
                if ({hsync_n, vsync_n} !== want[i - 3]) begin
                    $display("FAIL syncs_fixed[%0d]: hsync_n,vsync_n=%b exp=%b", i - 3, {hsync_n, vsync_n}, want[i - 3]);
                end else n_pass++;
            end
            drive(i < tab.size() ? tab[i] : idle(500, 100));
        end
    endtask

    task automatic test_commit_race();
        stim_t tab[$];
        tab.push_back(idle(1087, 516));
        tab.push_back(pwrite(0, 0, 3, 12'h0F0));
        tab.push_back(px(5, 2, 0, 0));
        test_pixels("race_same_frame", tab, RST_V);
        n_checks++;
        if (m_active[3] !== 12'hF00) $display("FAIL race_model: active3=%h exp=f00", m_active[3]);
        else n_pass++;
        tab.delete();
        tab.push_back(idle(1087, 516));
        tab.push_back(idle(0, 0));
        tab.push_back(idle(1, 0));
        tab.push_back(px(5, 2, 0, 0));
        test_pixels("race_next_frame", tab, 15'h7fff);
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp_v;
        stim_t s;
        s = px(5, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL reset_mid_pre: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            drive(s);
        end
        n_checks++;
        if ({rgb, de} !== {12'h0F0, 1'b1}) $display("FAIL reset_mid_active: rgb,de=%h exp=0f01", {rgb, de});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rgb, de, hsync_n, vsync_n} !== RST_V) begin
            $display("FAIL reset_mid_immediate: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, RST_V);
        end else n_pass++;
        sb.delete();
        repeat (3) sb.push_back(RST_V);
        m_shadow = '{default: '0};
        m_active = '{default: '0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                exp_v = sb.pop_front();
                n_checks++;
                if ({rgb, de, hsync_n, vsync_n} !== exp_v) begin
                    $display("FAIL reset_mid: out=%h exp=%h", {rgb, de, hsync_n, vsync_n}, exp_v);
                end else n_pass++;
            end
            if (i == 2) rst = 1'b0;
            drive(s);
        end
        n_checks++;
        if ({rgb, de} !== {12'h000, 1'b1}) $display("FAIL reset_mid_palette: rgb,de=%h exp=0001", {rgb, de});
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) tile_mem[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) pat_mem[i] = 8'($urandom);
        tile_mem[149] = 16'hA341;
        pat_mem[{8'h41, 3'd0}] = 8'h80;
        m_shadow = '{default: '0};
        m_active = '{default: '0};

        test_reset();
        test_palette_load();
        test_address_latency();
        test_background();
        test_outside();
        test_syncs();
        test_back_to_back();
        test_commit_race();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tile_pixel_pipe.md
# tile_pixel_pipe

Pixel-generation stage directly downstream of `graphic_counter`. Consumes the raster position (`cnt_h`, `cnt_v`), block coordinates (`blk_x`, `blk_y`), intra-block offsets (`off_x`, `off_y`) and `in_mem`. It fetches the tile attribute word from tile RAM and the glyph row from pattern ROM, then resolves the pixel through a 16-entry palette. Outputs are registered 12-bit RGB, data-enable and active-low syncs, all aligned to one fixed latency.

## Interface
- `H_SYNC_LEN`, 112: hsync asserted while `cnt_h` < this value.
- `V_SYNC_LEN`, 3: vsync asserted while `cnt_v` < this value.
- `TILES_X`, 72: tiles per row; tile address stride.
- `clk`  in  1  pixel clock, single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `cnt_h`  in  11  horizontal counter, 0..1087.
- `cnt_v`  in  10  vertical counter, 0..516.
- `blk_x`  in  7  tile column, 0..71.
- `blk_y`  in  6  tile row, 0..53.
- `off_x`  in  3  pixel within tile row, 0..7.
- `off_y`  in  3  line within tile, 0..7.
- `in_mem`  in  1  current position lies in the tile field.
- `tile_rd`  out  1  tile RAM read strobe.
- `tile_addr`  out  12  tile RAM address.
- `tile_data`  in  16  tile word, valid 1 cycle after `tile_rd`. Bits [7:0] glyph, [11:8] fg index, [15:12] bg index.
- `pat_addr`  out  11  pattern ROM address {glyph, off_y}.
- `pat_data`  in  8  glyph row, valid 1 cycle after address; bit 7 = leftmost pixel.
- `pal_we`  in  1  palette shadow write enable.
- `pal_addr`  in  4  palette entry.
- `pal_data`  in  12  RGB444 value {R,G,B}.
- `rgb`  out  12  pixel colour.
- `de`  out  1  data enable.
- `hsync_n`  out  1  horizontal sync, active-low.
- `vsync_n`  out  1  vertical sync, active-low.

## Operation
- **S0 (input cycle N)**
  - `tile_addr` = `blk_y`*72 + `blk_x`, computed as (blk_y<<6)+(blk_y<<3)+blk_x in 12 bits. Maximum is 3887; no overflow.
  - `tile_rd` = `in_mem`. `tile_addr` is driven combinationally from the inputs.
  - Sync raw values: hs = (`cnt_h` < `H_SYNC_LEN`), vs = (`cnt_v` < `V_SYNC_LEN`).
  - `frame_start` = (`cnt_h`==0 && `cnt_v`==0).
- **S1 (N+1)**
  - Registered `off_x`, `off_y`, `in_mem` and syncs available.
  - `pat_addr` = {tile_data[7:0], off_y_d1}.
  - fg/bg nibbles captured into S2 registers.
- **S2 (N+2)**
  - `pat_data` returns. bit = pat_data[7 - off_x_d2].
  - idx = bit ? fg : bg. Colour = active_palette[idx].
- **S3 (N+3)**
  - `rgb` <= de_d2 ? colour : 12'h000.
  - `de` <= in_mem_d2. `hsync_n` <= ~hs_d2. `vsync_n` <= ~vs_d2.
- **Palette**
  - `pal_we` writes `shadow[pal_addr]`.
  - `frame_start` in S0 copies shadow into active in that cycle.
  - If `pal_we` and `frame_start` coincide, the commit takes the pre-write shadow. The new value reaches active at the next frame start.
  - Active palette changes only at frame boundaries, so there is no tearing.
- Pipeline is free-running: no stall, no back-pressure.
- **Reset**
  - Holds `rgb`=0, `de`=0, `hsync_n`=1, `vsync_n`=1.
  - All pipeline registers and both palettes are cleared to 0. `tile_rd` is 0 while `rst` is asserted.
  - Reset mid-frame clears everything immediately. Valid output resumes 3 cycles after release, once inputs have been presented.

## Timing
- Latency is exactly 3 clocks from inputs at N to `rgb`/`de`/syncs at N+3. Every output has identical latency.
- Tile RAM and pattern ROM are synchronous with 1-cycle read latency. Zero-wait memories are required.
- `de` deasserts in the same cycle `rgb` is forced to 0. No partial pixel appears at field edges.
- At the `cnt_h` wrap 1087→0 and the `cnt_v` wrap 516→0, the raw syncs follow the counters with no special casing.
- Palette write to shadow: 1 cycle. Shadow to visible output: from the next `frame_start` onward, +3 cycles.

## Structure
- **Shared package `gpu_pkg`**
  - Constants: HW=1088, VW=517, TILES_X=72, TILES_Y=54, sync lengths, pipeline latency 3.
  - Type: tile word field layout.
  - `graphic_counter` uses the same package.
- **Sub-module `gpu_palette`**
  - 16×12 shadow bank and active bank, plus the write/commit logic.
  - Combinational read of the active bank by index.

## Test plan
- **Address and latency:** drive blk_x=5, blk_y=2, in_mem=1 → `tile_addr`=149 and `tile_rd`=1 in the same cycle. Set tile_data=16'hA341, pat_data=8'h80, off_x=0 and palette[3]=12'hF00 (committed) → at N+3, `rgb`=F00 and `de`=1.
- **Background pixel:** same as above with off_x=1 → `rgb`=palette[10].
- **Outside field:** in_mem=0 → `rgb`=0 and `de`=0 at N+3; `tile_rd`=0.
- **Syncs:** at cnt_h=111, `hsync_n`=0 three cycles later; at cnt_h=112, `hsync_n`=1. At cnt_v=2 then 3, `vsync_n` goes 0 then 1.
- **Palette commit race:** write pal[3]=0F0 in the frame_start cycle → that frame still shows F00; the next frame shows 0F0.
- **Reset mid-frame:** assert `rst` during active video → outputs are immediately rgb=0, de=0, hsync_n=1, vsync_n=1, and the palette reads 0 after release.
